mb_arbiter: RTL
===============

// Module: mb_arbiter
// PURPOSE
//  Shares one single-port 8-bit memory block among NM bus masters, e.g. the dictionary
//   finder, the inner interpreter and the comma/loader writer.
//  Each master raises req and keeps ownership (burst lock) for as long as req stays high.
//  Grants are round-robin. A watchdog forcibly revokes a grant that is held too long.
//  Sits between the masters' memory ports and the memory block; the memory has
//   1-cycle synchronous read.
// PARAMETERS
//  NM   3       number of masters (2..8)
//  ASZ  17      address width (128K)
//  DSZ  8       data width
//  TMO  1024    max cycles one grant may be held; 0 disables the watchdog
// PORTS
//  clk      in   1         clock, all state on posedge
//  rst      in   1         asynchronous, active-high reset
//  req      in   NM        per-master request/lock, level
//  we       in   NM        per-master write enable
//  ai       in   NM*ASZ    per-master address, master i at [i*ASZ +: ASZ]
//  vo       in   NM*DSZ    per-master write data, master i at [i*DSZ +: DSZ]
//  gnt      out  NM        one-hot grant, registered
//  rdy      out  NM        read data valid for master i (vi holds its data)
//  vi       out  DSZ       read data, broadcast = mem_vi
//  err      out  1         1-cycle pulse on watchdog revoke
//  mem_we   out  1         memory write enable
//  mem_ai   out  ASZ       memory address
//  mem_vo   out  DSZ       memory write data
//  mem_vi   in   DSZ       memory read data, valid 1 cycle after mem_ai
// BEHAVIOUR
//  Reset values (async on rst=1): gnt=0, rdy=0, err=0, state=IDLE, own=0, cnt=0,
//   mask=0, last=NM-1 so master 0 has top priority.
//  mem_* outputs are combinational from the owner while gnt!=0:
//   mem_ai=ai[own], mem_vo=vo[own], mem_we=we[own].
//  With gnt==0: mem_we=0, mem_ai=0, mem_vo=0. A master can never write unless granted.
//  Eligible set: elig = req & ~mask.
//  States:
//   IDLE: if elig!=0, pick the first eligible master scanning last+1, last+2, ...
//    mod NM; at the next edge own<=pick, gnt<=onehot(pick), cnt<=0, go GNT.
//    Otherwise stay in IDLE.
//   GNT: cnt increments each cycle, saturating.
//    If req[own]==0: gnt<=0, last<=own, go IDLE (normal release).
//    Else if TMO!=0 and cnt==TMO-1: gnt<=0, last<=own, mask[own]<=1, err<=1 for
//     one cycle, go IDLE (revoke).
//  Latency: req rises at edge n and is seen in IDLE -> gnt high after edge n+1.
//   The master's first address goes out in that cycle.
//  Release: req drops -> gnt low after the next edge. There is at least one dead
//   cycle (IDLE) between two grants, which serves as bus turnaround.
//  mask[i] clears on any cycle with req[i]==0. A revoked master must drop req
//   before it can be granted again.
//  rdy[i] <= gnt[i] & ~we[i] (registered), so rdy follows a read address by 1 cycle.
//   rdy may stay high for one cycle after gnt falls, for the last read.
//  Simultaneous release and new requests: handled by IDLE on the following cycle;
//   round-robin continues from last.
//  Simultaneous normal release and timeout on the same edge: treated as normal
//   release; no err, no mask.
//  req[i] high for a non-owner during GNT: it waits, with no effect on the owner.
//  cnt width: $clog2(TMO+1); it must not wrap.
//  Reset mid-grant: gnt and mem_we drop immediately (async); the in-flight write is
//   lost; masters restart their bursts.
//  Unused state encodings recover to IDLE.
// TESTING
//  Single request: req[1]=1 at t0 -> gnt=3'b010 at t0+1; ai[1]=5 -> mem_ai=5;
//   mem_vi=8'h41 -> rdy[1]=1, vi=8'h41 at t0+2.
//  Contention: req=3'b111 from reset, each drops after 4 grant cycles -> grant order
//   0,1,2,0; one idle cycle between grants.
//  Burst lock: master 0 holds req for 20 cycles while req[2]=1 -> gnt stays 3'b001
//   for all 20; then 3'b100 two edges after req[0] falls.
//  Watchdog, TMO=8: req[2] held -> gnt[2] revoked after 8 cycles, err pulses once;
//   req[2] stays high and is not re-granted until it toggles low for 1 cycle.
//  Write gating: we[1]=1, req[1]=0 -> mem_we=0. After grant, vo[1]=8'h20 at ai[1]=0x100
//   -> memory byte 0x100 reads back 8'h20.
//  Async reset mid-burst: rst pulses between edges during gnt=3'b001 -> gnt=0 and
//   mem_we=0 immediately; after release, req=3'b011 -> master 0 granted first.

Source files
------------

// File: rtl/mb_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NM masters.
// Grants are burst-locked while req stays high; a watchdog revokes overlong grants.
module mb_arbiter #(
  parameter int NM  = 3,
  parameter int ASZ = 17,
  parameter int DSZ = 8,
  parameter int TMO = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NM-1:0]     req_i,
  input  logic [NM-1:0]     we_i,
  input  logic [NM*ASZ-1:0] ai_i,
  input  logic [NM*DSZ-1:0] vo_i,
  output logic [NM-1:0]     gnt_o,
  output logic [NM-1:0]     rdy_o,
  output logic [DSZ-1:0]    vi_o,
  output logic              err_o,
  output logic              mem_we_o,
  output logic [ASZ-1:0]    mem_ai_o,
  output logic [DSZ-1:0]    mem_vo_o,
  input  logic [DSZ-1:0]    mem_vi_i
);
  localparam int OW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] TLIM = (TMO > 0) ? CW'(TMO - 1) : '0;

  typedef enum logic [1:0] {IDLE = 2'd0, GNT = 2'd1} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] own_q, own_d, last_q, last_d, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NM-1:0] gnt_q, gnt_d, rdy_q, rdy_d, mask_q, mask_d, elig;
  logic          err_q, err_d, found;
  int            pidx;

  assign elig = req_i & ~mask_q;

  // Scan last+1, last+2, ... so the most recent owner ends up lowest priority.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    pidx  = 0;
    for (int k = 1; k <= NM; k++) begin
      pidx = (int'(last_q) + k) % NM;
      if (!found && elig[pidx]) begin
        found = 1'b1;
        pick  = OW'(pidx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    err_d   = 1'b0;
    mask_d  = mask_q & req_i;
    rdy_d   = gnt_q & ~we_i;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          own_d   = pick;
          gnt_d   = NM'(1) << pick;
          cnt_d   = '0;
          state_d = GNT;
        end
      end
      GNT: begin
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        // A release on the same edge as the timeout wins: no err, no mask.
        if (!req_i[own_q]) begin
          gnt_d   = '0;
          last_d  = own_q;
          state_d = IDLE;
        end else if (TMO != 0 && cnt_q == TLIM) begin
          gnt_d         = '0;
          last_d        = own_q;
          mask_d[own_q] = 1'b1;
          err_d         = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= '0;
      last_q  <= OW'(NM - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      rdy_q   <= '0;
      err_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  // Memory port follows the owner only while a grant is live, so no stray writes.
  always_comb begin
    mem_we_o = 1'b0;
    mem_ai_o = '0;
    mem_vo_o = '0;
    if (gnt_q != '0) begin
      mem_we_o = we_i[own_q];
      mem_ai_o = ai_i[own_q*ASZ +: ASZ];
      mem_vo_o = vo_i[own_q*DSZ +: DSZ];
    end
  end

  assign gnt_o = gnt_q;
  assign rdy_o = rdy_q;
  assign err_o = err_q;
  assign vi_o  = mem_vi_i;
endmodule
